// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: accepts 8-pixel pushes from the background fetcher
// on the rising edge of its valid level, and shifts one colour index per
// T-cycle toward the pixel mixer, silently dropping the first SCX mod 8
// pixels of each scanline.
module bg_pixel_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            tclk_in,
  input  logic            line_start_in,
  input  logic [7:0]      SCX_in,
  input  logic            push_valid_in,
  input  logic [7:0][1:0] push_pixels_in,
  input  logic            stall_in,
  output logic            empty_out,
  output logic            ready_out,
  output logic [4:0]      count_out,
  output logic [1:0]      pixel_out,
  output logic            pixel_valid_out,
  output logic            overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2:0]            discard_q, discard_d;
  logic                  push_prev_q, push_prev_d;
  logic [1:0]            pixel_q, pixel_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  overflow_q, overflow_d;

  logic push_edge;
  logic push_ok;
  logic pop;
  logic unused_scx_hi;

  // Only the fine-scroll bits matter; the coarse scroll is handled by the fetcher.
  assign unused_scx_hi = ^SCX_in[7:3];

  assign empty_out       = (count_q == '0);
  assign ready_out       = (count_q <= CNT_W'(DEPTH - 8));
  assign count_out       = count_q;
  assign pixel_out       = pixel_q;
  assign pixel_valid_out = pixel_valid_q;
  assign overflow_out    = overflow_q;

  // Push is a rising edge of the fetcher's valid level; pop uses the
  // registered count, so freshly pushed pixels wait for the next T-cycle.
  assign push_edge = push_valid_in & ~push_prev_q;
  assign push_ok   = push_edge & ready_out & ~line_start_in;
  assign pop       = tclk_in & ~stall_in & (count_q != '0) & ~line_start_in;

  // Write the 8 pushed pixels into the slots wptr..wptr+7 (mod DEPTH).
  always_comb begin
    logic [PTR_W-1:0] slot_off;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    mem_d    = mem_q;
    slot_off = '0;
    if (push_ok) begin
      for (int j = 0; j < DEPTH; j++) begin
        slot_off = PTR_W'(j) - wptr_q;
        // Offset below 8 means this slot lies inside the push window.
        if (!slot_off[PTR_W-1]) mem_d[j] = push_pixels_in[slot_off[PTR_W-2:0]];
      end
    end
  end

  // Pixel storage.
  always_ff @(posedge clk_in) begin
    // NOTE: the buffer has no reset; count and pointers alone decide which
    // slots are meaningful, so stale contents are never observed.
    mem_q <= mem_d;
  end

  // Next-state for occupancy, pointers, discard counter and output pixel.
  always_comb begin
    push_prev_d   = push_valid_in;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    overflow_d    = overflow_q;

    if (line_start_in) begin
      // New scanline wins over any coincident push or pop.
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      discard_d  = SCX_in[2:0];
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          pixel_d       = mem_q[rptr_q];
          pixel_valid_d = 1'b1;
        end
      end
      if (push_ok) wptr_d = wptr_q + PTR_W'(8);
      if (push_edge && !ready_out) overflow_d = 1'b1;
      count_d = count_q + (push_ok ? CNT_W'(8) : '0) - (pop ? CNT_W'(1) : '0);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      push_prev_q   <= 1'b0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
      discard_q     <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      push_prev_q   <= push_prev_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      discard_q     <= discard_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule
